// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Shares one single-port frame-buffer RAM between VGA scan-out and a pixel
// writer. Scan-out has absolute priority: every active pixel issues one read.
// The writer (valid/ready) is granted the RAM only in blanking cycles.
// Everything runs in the pixel-clock domain.
//
// Ports:
//   i_clk, i_rst          pixel clock, async active-high reset
//   i_hblank_n/i_vblank_n blanking inputs, low while blanking
//   i_wr_valid/addr/data  writer request (addr is linear y*H_ACTIVE+x)
//   o_wr_ready            writer grant, transfer on valid & ready
//   o_mem_addr/we/wdata   RAM port (combinational)
//   i_mem_rdata           RAM read data, RD_LAT cycles after the address
//   o_pix/o_pix_valid     scan-out pixel, RD_LAT+1 cycles after the fetch
//   o_wr_oob              pulse one cycle after an out-of-range write is consumed
//   o_line_err            pulse one cycle after an hblank entry with a bad line length
//
// States:
//   SYNC_WAIT | after reset: no fetches, waiting for vblank to align to a frame
//   RUN       | fetching one pixel per active cycle, writes granted in blank
module vga_fb_arbiter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 12,
    parameter int RD_LAT   = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_hblank_n,
    input  logic              i_vblank_n,
    input  logic              i_wr_valid,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [DATA_W-1:0] o_pix,
    output logic              o_pix_valid,
    output logic              o_wr_oob,
    output logic              o_line_err
);

    // x must be able to hold H_ACTIVE itself plus headroom for over-long lines.
    localparam int X_W = $clog2(H_ACTIVE + 1) + 1;
    // One extra bit so the frame size is representable even when it equals 2^ADDR_W.
    localparam logic [ADDR_W:0]  FB_SIZE = (ADDR_W + 1)'(H_ACTIVE * V_ACTIVE);
    localparam logic [X_W-1:0]   X_LINE  = X_W'(H_ACTIVE);

    typedef enum logic {
        SYNC_WAIT = 1'b0,
        RUN       = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_fetch_addr;
    logic [X_W-1:0]      r_x;
    logic                r_hblank_n_d;
    logic [RD_LAT-1:0]   r_rd_vld;
    logic [DATA_W-1:0]   r_pix;
    logic                r_pix_valid;
    logic                r_wr_oob;
    logic                r_line_err;

    logic                w_active;
    logic                w_fetch;
    logic                w_wr_xfer;
    logic                w_in_range;
    logic                w_hblank_entry;

    assign w_active       = i_hblank_n & i_vblank_n;
    assign w_wr_xfer      = i_wr_valid & ~w_active;
    assign w_in_range     = ({1'b0, i_wr_addr} < FB_SIZE);
    assign w_hblank_entry = r_hblank_n_d & ~i_hblank_n;

    always_comb begin
        w_state_nxt = r_state;
        w_fetch     = 1'b0;
        o_wr_ready  = ~w_active;
        o_mem_addr  = '0;
        o_mem_we    = 1'b0;
        o_mem_wdata = '0;
        case (r_state)
            SYNC_WAIT: if (!i_vblank_n) w_state_nxt = RUN;
            RUN:       w_fetch = w_active;
        endcase
        // Fetch only happens in active cycles and writes only in blank,
        // so the two never compete for the port.
        if (w_fetch) begin
            o_mem_addr = r_fetch_addr;
        end else if (w_wr_xfer) begin
            o_mem_addr  = i_wr_addr;
            o_mem_wdata = i_wr_data;
            o_mem_we    = w_in_range;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= SYNC_WAIT;
            r_fetch_addr <= '0;
            r_x          <= '0;
            r_hblank_n_d <= 1'b0;
            r_rd_vld     <= '0;
            r_pix        <= '0;
            r_pix_valid  <= 1'b0;
            r_wr_oob     <= 1'b0;
            r_line_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hblank_n_d <= i_hblank_n;

            // vblank wins over everything: the frame restarts at address 0.
            if (!i_vblank_n) begin
                r_fetch_addr <= '0;
            end else if (w_fetch) begin
                r_fetch_addr <= r_fetch_addr + ADDR_W'(1);
            end

            if (!i_vblank_n || w_hblank_entry) begin
                r_x <= '0;
            end else if (w_fetch) begin
                r_x <= r_x + X_W'(1);
            end

            // hblank entries inside vblank carry no line, so they are not checked.
            r_line_err <= (r_state == RUN) && w_hblank_entry && i_vblank_n
                          && (r_x != X_LINE);
            r_wr_oob   <= w_wr_xfer & ~w_in_range;

            r_rd_vld[0] <= w_fetch;
            for (int i = 1; i < RD_LAT; i++) begin
                r_rd_vld[i] <= r_rd_vld[i-1];
            end
            r_pix_valid <= r_rd_vld[RD_LAT-1];
            r_pix       <= r_rd_vld[RD_LAT-1] ? i_mem_rdata : '0;
        end
    end

    assign o_pix       = r_pix;
    assign o_pix_valid = r_pix_valid;
    assign o_wr_oob    = r_wr_oob;
    assign o_line_err  = r_line_err;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int AW = 6;
    localparam int DW = 12;
    localparam int RL = 1;
    localparam int FB = H * V;
    localparam int MSZ = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          hb_n = 1'b0;
    logic          vb_n = 1'b1;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] pix;
    logic          pix_valid;
    logic          wr_oob;
    logic          line_err;

    vga_fb_arbiter #(
        .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_hblank_n(hb_n), .i_vblank_n(vb_n),
        .i_wr_valid(wr_valid), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .o_wr_ready(wr_ready), .o_mem_addr(mem_addr), .o_mem_we(mem_we),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_pix(pix),
        .o_pix_valid(pix_valid), .o_wr_oob(wr_oob), .o_line_err(line_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame-buffer RAM, one-cycle read latency. Unwritten locations return a
    // fixed preload pattern.
    function automatic int preload(input int a);
        return (a * 37 + 5) & 12'hFFF;
    endfunction

    logic [DW-1:0] ram [MSZ];
    bit            ram_wr [MSZ];
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr]    <= mem_wdata;
            ram_wr[mem_addr] <= 1'b1;
        end
        mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : DW'(preload(int'(mem_addr)));
    end

    // Scoreboard
    typedef struct {
        int c; bit fetch; bit wr; int addr; int we; int wdata; int ready;
    } port_t;
    typedef struct { int c; int v; } pix_t;

    port_t port_q[$];
    pix_t  pix_q[$];
    int    oob_q[$];
    int    lerr_q[$];

    int n_cmp = 0;
    int n_err = 0;
    bit started = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: expected frame-buffer contents, the number of pixels
    // fetched since the last vblank, and the number fetched on the current line.
    int  shadow [MSZ];
    bit  m_synced = 0;
    int  m_cnt = 0;
    int  m_line = 0;
    bit  m_prev_hb = 0;

    // Writer state
    bit  w_pend = 0;
    int  w_addr = 0;
    int  w_data = 0;
    int  wr_pct = 40;

    task automatic step(input bit hb, input bit vb, input bit do_rst = 1'b0);
        port_t pe;
        pix_t  pp;
        bit    act;
        @(posedge clk);
        #1;
        rst  = do_rst;
        hb_n = hb;
        vb_n = vb;
        act  = hb & vb;
        pe.c = cyc; pe.fetch = 0; pe.wr = 0; pe.addr = 0; pe.we = 0; pe.wdata = 0;
        pe.ready = act ? 0 : 1;
        if (do_rst) begin
            started = 1;
            pix_q.delete(); oob_q.delete(); lerr_q.delete();
            m_synced = 0; m_cnt = 0; m_line = 0; m_prev_hb = 0;
            wr_valid = 0;
            port_q.push_back(pe);
            return;
        end
        if (!w_pend && $urandom_range(0, 99) < wr_pct) begin
            w_pend = 1;
            w_addr = $urandom_range(0, MSZ - 1);
            w_data = $urandom_range(0, 4095);
        end
        wr_valid = w_pend;
        wr_addr  = AW'(w_addr);
        wr_data  = DW'(w_data);
        if (m_synced && act) begin
            pe.fetch = 1;
            pe.addr  = m_cnt % MSZ;
            pp.c = cyc + RL + 1;
            pp.v = shadow[m_cnt % MSZ];
            pix_q.push_back(pp);
            m_cnt++;
            m_line++;
        end else if (w_pend && !act) begin
            pe.wr = 1;
            pe.addr = w_addr;
            pe.we = (w_addr < FB) ? 1 : 0;
            pe.wdata = w_data;
            if (w_addr < FB) shadow[w_addr] = w_data;
            else oob_q.push_back(cyc + 1);
            w_pend = 0;
        end
        if (m_synced && m_prev_hb && !hb && vb && m_line != H) lerr_q.push_back(cyc + 1);
        if (m_prev_hb && !hb) m_line = 0;
        if (!vb) begin
            m_cnt = 0; m_line = 0; m_synced = 1;
        end
        m_prev_hb = hb;
        port_q.push_back(pe);
    endtask

    task automatic set_req(input int a, input int d);
        w_pend = 1; w_addr = a; w_data = d;
    endtask

    task automatic line(input int nact, input int nbl);
        for (int i = 0; i < nact; i++) step(1, 1);
        for (int i = 0; i < nbl; i++) step(0, 1);
    endtask

    task automatic vblank_lines(input int n);
        for (int l = 0; l < n; l++) begin
            for (int i = 0; i < H; i++) step(1, 0);
            for (int i = 0; i < 3; i++) step(0, 0);
        end
    endtask

    task automatic frame(input int nbl);
        vblank_lines(2);
        for (int l = 0; l < V; l++) line(H, nbl);
    endtask

    // Monitor
    initial begin
        port_t pe;
        pix_t  pp;
        int    ev, ep;
        forever begin
            @(negedge clk);
            if (started) begin
                if (port_q.size() != 0 && port_q[0].c == cyc) begin
                    pe = port_q.pop_front();
                    chk("wr_ready", int'(wr_ready), pe.ready);
                    chk("mem_we", int'(mem_we), pe.we);
                    if (pe.fetch || pe.wr) chk("mem_addr", int'(mem_addr), pe.addr);
                    if (pe.we != 0) chk("mem_wdata", int'(mem_wdata), pe.wdata);
                end
                ev = 0; ep = 0;
                if (pix_q.size() != 0 && pix_q[0].c == cyc) begin
                    pp = pix_q.pop_front();
                    ev = 1; ep = pp.v;
                end
                chk("pix_valid", int'(pix_valid), ev);
                chk("pix", int'(pix), ep);
                ev = 0;
                if (oob_q.size() != 0 && oob_q[0] == cyc) begin
                    void'(oob_q.pop_front());
                    ev = 1;
                end
                chk("wr_oob", int'(wr_oob), ev);
                ev = 0;
                if (lerr_q.size() != 0 && lerr_q[0] == cyc) begin
                    void'(lerr_q.pop_front());
                    ev = 1;
                end
                chk("line_err", int'(line_err), ev);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog at cycle %0d: got timeout expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MSZ; i++) shadow[i] = preload(i);

        step(1, 1, 1);
        step(1, 1, 1);
        // Mid-frame after reset: nothing fetched, writer still served in blank.
        line(H, 3);
        line(H, 3);
        frame(3);
        frame(3);

        // Directed writes: in range, stalled from active, range boundaries.
        vblank_lines(1);
        set_req(10, 12'hF0A);
        line(H, 3);
        set_req(31, 12'h123);
        step(0, 1);
        set_req(32, 12'h456);
        step(0, 1);
        set_req(63, 12'h789);
        step(0, 1);
        line(H, 3);
        line(H, 3);
        line(H, 3);
        frame(3);

        // Malformed lines: short then long.
        vblank_lines(2);
        line(H, 3);
        line(H - 1, 3);
        line(H + 1, 3);
        line(H, 3);
        frame(3);

        // Random traffic.
        for (int f = 0; f < 20; f++) begin
            wr_pct = $urandom_range(10, 90);
            frame($urandom_range(2, 4));
        end

        // Reset in the middle of an active line.
        vblank_lines(2);
        line(H, 3);
        for (int i = 0; i < 3; i++) step(1, 1);
        step(1, 1, 1);
        for (int i = 0; i < 5; i++) step(1, 1);
        for (int i = 0; i < 3; i++) step(0, 1);
        line(H, 3);
        frame(3);
        frame(2);

        wr_pct = 0;
        for (int i = 0; i < 6; i++) step(0, 0);
        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
